// File: rtl/audio_pkg.sv
// Shared audio-path constants and the default sample type for the codec interface.
package audio_pkg;

    // Default per-channel sample width used across the NCO/mixer/codec path
    localparam int DEF_SAMPLE_W = 16;

    // I2S framing: two 32-bit slots per frame
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/bclk_gen.sv
// Codec bit-clock generator: divides Clk down to bclk, flags the bclk falling
// edge and tracks the bit position within the 64-bit I2S frame.
module bclk_gen
    import audio_pkg::*;
#(
    parameter int HALF_DIV = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          bclk_o,
    output logic                          fall_o,
    output logic                          wrap_o,
    output logic [$clog2(FRAME_BITS)-1:0] bit_cnt_next_o
);

    localparam int DIV_W = $clog2(HALF_DIV);
    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             tick;
    logic             fall;

    // Half-period divider, bclk toggle and frame bit counter advancing on bclk fall
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        fall      = tick && bclk_q;
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        bclk_d    = tick ? ~bclk_q : bclk_q;
        bit_cnt_d = fall ? bit_cnt_q + 1'b1 : bit_cnt_q;
    end

    // Divider and bit-position state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bclk_o         = bclk_q;
    assign fall_o         = fall;
    assign wrap_o         = fall && (bit_cnt_q == CNT_LAST);
    assign bit_cnt_next_o = bit_cnt_q + 1'b1;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: stages one stereo pair from the producer, latches it at the
// frame boundary and shifts it MSB-first to the codec one bclk after each lrclk edge.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int HALF_DIV = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic signed [SAMPLE_W-1:0] sample_l,
    input  logic signed [SAMPLE_W-1:0] sample_r,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       dacdat,
    output logic                       underrun
);

    localparam int CNT_W  = $clog2(FRAME_BITS);
    localparam int SLOT_W = $clog2(SLOT_BITS);

    // Slot bit k carries sample bit SAMPLE_W-k for k=1..SAMPLE_W; bit 0 and the
    // tail of the slot are zero. Left-justifying the word into the slot turns
    // that into a single index of (SLOT_BITS - k).
    function automatic logic slot_bit(input logic [SAMPLE_W-1:0] word,
                                      input logic [SLOT_W-1:0]   k);
        logic [SLOT_BITS-1:0] w;
        logic [SLOT_W-1:0]    idx;
        w   = {word, {(SLOT_BITS - SAMPLE_W){1'b0}}};
        idx = '0 - k;
        return (k != '0) && w[idx];
    endfunction

    logic             fall;
    logic             wrap;
    logic             bclk_int;
    logic [CNT_W-1:0] bit_cnt_next;

    bclk_gen #(
        .HALF_DIV(HALF_DIV)
    ) u_bclk_gen (
        .clk_i          (Clk),
        .rst_i          (Reset),
        .bclk_o         (bclk_int),
        .fall_o         (fall),
        .wrap_o         (wrap),
        .bit_cnt_next_o (bit_cnt_next)
    );

    logic signed [SAMPLE_W-1:0] stage_l_q, stage_l_d;
    logic signed [SAMPLE_W-1:0] stage_r_q, stage_r_d;
    logic signed [SAMPLE_W-1:0] hold_l_q, hold_l_d;
    logic signed [SAMPLE_W-1:0] hold_r_q, hold_r_d;
    logic                       stage_full_q, stage_full_d;
    logic                       ready_q, ready_d;
    logic                       lrclk_q, lrclk_d;
    logic                       dacdat_q, dacdat_d;
    logic                       underrun_q, underrun_d;
    logic                       accept;

    // Handshake, frame load and next serial bit. The load checks the staging
    // state before this cycle's write, so a pair arriving on the wrap itself
    // counts as late and is used one frame later.
    always_comb begin
        accept       = sample_valid && ready_q;
        stage_l_d    = stage_l_q;
        stage_r_d    = stage_r_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        stage_full_d = stage_full_q;
        lrclk_d      = lrclk_q;
        dacdat_d     = dacdat_q;
        underrun_d   = 1'b0;

        if (wrap) begin
            if (stage_full_q) begin
                hold_l_d     = stage_l_q;
                hold_r_d     = stage_r_q;
                stage_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (accept) begin
            stage_l_d    = sample_l;
            stage_r_d    = sample_r;
            stage_full_d = 1'b1;
        end

        // Slot bit 0 is always zero, so the stale hold value at the wrap is harmless
        if (fall) begin
            lrclk_d  = bit_cnt_next[CNT_W-1];
            dacdat_d = slot_bit(bit_cnt_next[CNT_W-1] ? hold_r_q : hold_l_q,
                                bit_cnt_next[SLOT_W-1:0]);
        end

        ready_d = !stage_full_d;
    end

    // Staging, hold and registered codec-side outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stage_l_q    <= '0;
            stage_r_q    <= '0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            stage_full_q <= 1'b0;
            ready_q      <= 1'b1;
            lrclk_q      <= 1'b0;
            dacdat_q     <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            stage_l_q    <= stage_l_d;
            stage_r_q    <= stage_r_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            stage_full_q <= stage_full_d;
            ready_q      <= ready_d;
            lrclk_q      <= lrclk_d;
            dacdat_q     <= dacdat_d;
            underrun_q   <= underrun_d;
        end
    end

    assign sample_ready = ready_q;
    assign bclk         = bclk_int;
    assign lrclk        = lrclk_q;
    assign dacdat       = dacdat_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx with HALF_DIV=2 (bclk period 4 Clk, frame 256 Clk).
module tb_i2s_tx;
    import audio_pkg::*;

    localparam int SW = 16;
    localparam int HD = 2;
    localparam int FRAME_CLK = 64 * 2 * HD;

    logic    Clk = 1'b0;
    logic    Reset;
    sample_t sample_l, sample_r;
    logic    sample_valid;
    logic    sample_ready, bclk, lrclk, dacdat, underrun;

    i2s_tx #(
        .SAMPLE_W (SW),
        .HALF_DIV (HD)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .dacdat       (dacdat),
        .underrun     (underrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    // One record per frame: pairs offered at frame start, an optional pair
    // offered only in the wrap cycle, the words expected on the wire in this
    // frame and whether underrun must pulse at this frame's closing wrap.
    typedef struct {
        int          n_wr;
        pair_t       p0;
        pair_t       p1;
        bit          late;
        pair_t       lp;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        int          exp_unr;
    } frame_vec_t;

    int    tests = 0;
    int    fails = 0;
    int    frame_no = 0;
    pair_t pend_q[$];
    int    acc_frame[$];
    int    acc_step[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Run one full frame window of Clk cycles, feeding queued pairs and
    // collecting the serial slots on bclk rises.
    task automatic run_frame(input frame_vec_t v);
        logic [31:0] slot_l, slot_r;
        int          rises, lr_err, unr;
        logic        prev_bclk, rdy;
        slot_l = '0; slot_r = '0;
        rises = 0; lr_err = 0; unr = 0;
        if (v.n_wr >= 1) pend_q.push_back(v.p0);
        if (v.n_wr >= 2) pend_q.push_back(v.p1);
        prev_bclk = bclk;
        for (int s = 1; s <= FRAME_CLK; s++) begin
            if (s == FRAME_CLK && v.late) pend_q.push_back(v.lp);
            if (pend_q.size() > 0) begin
                sample_valid = 1'b1;
                sample_l     = pend_q[0].l;
                sample_r     = pend_q[0].r;
            end else begin
                sample_valid = 1'b0;
            end
            rdy = sample_ready;
            @(posedge Clk); #1;
            if (sample_valid && rdy) begin
                void'(pend_q.pop_front());
                acc_frame.push_back(frame_no);
                acc_step.push_back(s);
                check($sformatf("f%0d ready low after accept", frame_no), 32'(sample_ready), 32'd0);
            end
            if (bclk && !prev_bclk) begin
                if (rises < 64) begin
                    if (lrclk !== (rises >= 32)) lr_err++;
                    if (rises < 32) slot_l = {slot_l[30:0], dacdat};
                    else            slot_r = {slot_r[30:0], dacdat};
                end
                rises++;
            end
            prev_bclk = bclk;
            if (underrun) unr++;
        end
        sample_valid = 1'b0;
        check($sformatf("f%0d bclk rises", frame_no), 32'(rises), 32'd64);
        check($sformatf("f%0d lrclk errors", frame_no), 32'(lr_err), 32'd0);
        check($sformatf("f%0d left slot", frame_no), slot_l, {1'b0, v.exp_l, 15'd0});
        check($sformatf("f%0d right slot", frame_no), slot_r, {1'b0, v.exp_r, 15'd0});
        check($sformatf("f%0d underrun cycles", frame_no), 32'(unr), 32'(v.exp_unr));
        frame_no++;
    endtask

    frame_vec_t vecs[7];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        pair_t A, B, C, D, E, Z;
        frame_vec_t post;
        int          rises;
        logic        prev_bclk, rdy;

        A = '{16'hA5F0, 16'h0F0F};
        B = '{16'h8000, 16'h7FFF};
        C = '{16'h1234, 16'h1234};
        D = '{16'h0001, 16'hFFFF};
        E = '{16'h5555, 16'hAAAA};
        Z = '{16'h0000, 16'h0000};

        //             n_wr p0 p1 late lp  exp_l        exp_r        unr
        vecs[0] = '{1, A, Z, 1'b0, Z, 16'h0000, 16'h0000, 0}; // zeros, A staged
        vecs[1] = '{0, Z, Z, 1'b0, Z, 16'hA5F0, 16'h0F0F, 1}; // A out, nothing staged
        vecs[2] = '{2, B, C, 1'b0, Z, 16'hA5F0, 16'h0F0F, 0}; // A repeats, C held off
        vecs[3] = '{0, Z, Z, 1'b0, Z, 16'h8000, 16'h7FFF, 0}; // B out, C staged
        vecs[4] = '{0, Z, Z, 1'b1, D, 16'h1234, 16'h1234, 1}; // D offered on the wrap
        vecs[5] = '{0, Z, Z, 1'b0, Z, 16'h1234, 16'h1234, 0}; // C repeats, D loads next
        vecs[6] = '{0, Z, Z, 1'b0, Z, 16'h0001, 16'hFFFF, 1}; // D out

        Reset = 1'b1;
        sample_valid = 1'b0;
        sample_l = '0;
        sample_r = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset bclk", 32'(bclk), 32'd0);
        check("reset lrclk", 32'(lrclk), 32'd0);
        check("reset dacdat", 32'(dacdat), 32'd0);
        check("reset ready", 32'(sample_ready), 32'd1);
        check("reset underrun", 32'(underrun), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Acceptance points: A and B at the first cycle of their frame, C only
        // one cycle after the wrap that loads B, D exactly on the wrap cycle.
        check("accept count", 32'(acc_frame.size()), 32'd4);
        if (acc_frame.size() == 4) begin
            check("A accept frame", 32'(acc_frame[0]), 32'd0);
            check("A accept step", 32'(acc_step[0]), 32'd1);
            check("B accept frame", 32'(acc_frame[1]), 32'd2);
            check("B accept step", 32'(acc_step[1]), 32'd1);
            check("C accept frame", 32'(acc_frame[2]), 32'd3);
            check("C accept step", 32'(acc_step[2]), 32'd1);
            check("D accept frame", 32'(acc_frame[3]), 32'd4);
            check("D accept step", 32'(acc_step[3]), 32'(FRAME_CLK));
        end

        // Reset in the middle of the right slot, with a pair sitting in staging
        rises = 0;
        prev_bclk = bclk;
        for (int s = 0; s < FRAME_CLK && rises < 41; s++) begin
            sample_valid = (pend_q.size() == 0) && (acc_frame.size() == 4);
            sample_l = E.l;
            sample_r = E.r;
            rdy = sample_ready;
            @(posedge Clk); #1;
            if (sample_valid && rdy) acc_frame.push_back(frame_no);
            if (bclk && !prev_bclk) rises++;
            prev_bclk = bclk;
        end
        sample_valid = 1'b0;
        check("pre-reset bit position", 32'(rises), 32'd41);
        check("pre-reset bclk", 32'(bclk), 32'd1);
        check("pre-reset lrclk", 32'(lrclk), 32'd1);
        check("pre-reset dacdat", 32'(dacdat), 32'd1);
        check("pre-reset ready", 32'(sample_ready), 32'd0);
        #2;
        Reset = 1'b1;
        #1;
        check("async reset bclk", 32'(bclk), 32'd0);
        check("async reset lrclk", 32'(lrclk), 32'd0);
        check("async reset dacdat", 32'(dacdat), 32'd0);
        check("async reset ready", 32'(sample_ready), 32'd1);
        check("async reset underrun", 32'(underrun), 32'd0);
        #1;
        Reset = 1'b0;

        // Staged pair is discarded: the restarted frame is all zeros and its
        // closing wrap finds nothing staged.
        post = '{0, Z, Z, 1'b0, Z, 16'h0000, 16'h0000, 1};
        run_frame(post);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Consumer end of the NCO sample path: accepts signed 16-bit stereo samples over a valid/ready handshake and serialises them to the audio codec DAC in I2S format.
- Generates the codec bit clock (bclk), word-select (lrclk) and serial data (dacdat) from the system clock.
- Sits between the voice mixer/NCO outputs and the codec pins. Runs on Clk; codec is slave to bclk/lrclk.

Parameters:
- SAMPLE_W, 16, sample width per channel (must be <= 31).
- HALF_DIV, 8, Clk cycles per bclk half-period (>= 2). Frame rate = f_Clk / (128*HALF_DIV).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- sample_l  in  SAMPLE_W  signed left sample
- sample_r  in  SAMPLE_W  signed right sample
- sample_valid  in  1  producer has a sample pair
- sample_ready  out  1  staging register empty; a pair is accepted when valid&&ready
- bclk  out  1  codec bit clock
- lrclk  out  1  word select, 0=left, 1=right
- dacdat  out  1  serial data, MSB first
- underrun  out  1  one-Clk pulse when a frame starts with no new pair staged

Behaviour:
- Reset (async): bclk=0, lrclk=0, dacdat=0, sample_ready=1, underrun=0, div_cnt=0, bit_cnt=0, staging/holding regs=0, stage_full=0.
- Divider: div_cnt counts 0..HALF_DIV-1. When div_cnt==HALF_DIV-1, it wraps to 0 and bclk toggles. A fall event is that cycle with bclk==1.
- At each fall event: bit_cnt <= bit_cnt+1 mod 64. lrclk, dacdat are registered on the same edge as bclk falls, computed from the new bit_cnt.
- Slot mapping, with k = bit_cnt mod 32:
  - lrclk = bit_cnt[5].
  - dacdat = hold_x[SAMPLE_W-k] for k in 1..SAMPLE_W (x = L when bit_cnt<32, else R).
  - dacdat = 0 for k=0 and k>SAMPLE_W.
  - This places the MSB one bclk after the lrclk edge (I2S). The codec samples on bclk rise.
- Handshake:
  - sample_ready = !stage_full, registered.
  - On valid&&ready, the pair is written to staging and stage_full is set.
  - Data presented while ready=0 is ignored. The producer must hold it.
- Frame load, at the fall event taking bit_cnt 63->0:
  - If stage_full: hold_l/hold_r <= staging, stage_full cleared, so ready rises on the next cycle.
  - Else: hold regs keep their previous value (last pair repeats) and underrun pulses for that single Clk.
- Simultaneous write and frame load in the same cycle with stage empty: the load sees empty (underrun fires), the write lands in staging, and that pair is used at the next frame.
- Throughput: at most one pair per 64 bclk. Latency from acceptance to MSB on dacdat is at most 1 frame + 1 bclk.
- First frame after reset transmits zeros with no underrun. The first load occurs at the first 63->0 wrap.
- Reset mid-frame: all outputs and registers return to reset values immediately. Serialisation restarts at bit_cnt=0 with bclk low.
- All arithmetic is unsigned counters. Samples are passed bit-exact; no sign extension or truncation.

Decomposition:
- Shared package audio_pkg: SAMPLE_W default, SLOT_BITS=32, FRAME_BITS=64, and typedef sample_t = logic signed [SAMPLE_W-1:0].
- One natural sub-module: bclk_gen (divider, bclk toggle, fall-event strobe, bit_cnt). Staging, hold and shift muxing stay in i2s_tx.

Test Plan (HALF_DIV=2, SAMPLE_W=16: bclk period 4 Clk, frame 256 Clk):
1. Reset held, then released -> all outputs at reset values; sample_ready=1; bclk toggles every 2 Clk; lrclk=0 for 32 bclk then 1 for 32; dacdat=0 throughout frame 0; no underrun.
2. Write L=0xA5F0, R=0x0F0F in frame 0 -> ready drops the next cycle. In frame 1, dacdat sampled on bclk rises 1..16 after the lrclk fall gives 0xA5F0 MSB-first, then 0x0F0F after the lrclk rise; slot bits 0 and 17..31 are 0.
3. No write before the frame 1->2 boundary -> underrun high for exactly 1 Clk at the wrap; frame 2 repeats 0xA5F0/0x0F0F.
4. Write 0x8000/0x7FFF, then hold valid with 0x1234/0x1234 while ready=0 -> the second pair is not accepted until after the next frame load. Frames show 0x8000/0x7FFF, then 0x1234/0x1234.
5. Assert valid in exactly the cycle of the 63->0 fall event with stage empty -> underrun pulses; that pair appears in the following frame.
6. Assert Reset for 1 Clk mid-right-slot -> bclk, lrclk, dacdat=0 and sample_ready=1 asynchronously; the next frame starts from bit_cnt=0 with zeros.
